// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution operand feeder.
// Holds the feeder state encoding, the default operand width and the MAC
// pipeline latency that sets how long the feeder drains before a result is final.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRIME,
    ISSUE,
    DRAIN1,
    DRAIN2,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 14;

  // Cycles from the MAC capturing its last operand pair to f being final.
  // DRAIN1 covers MAC_LAT-1 cycles; DRAIN2 is the cycle f is sampled and cleared.
  localparam int MAC_LAT = 2;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/conv_feeder_rf.sv
// conv_feeder_rf: small register file, one synchronous write port and one
// combinational read port. ZERO_RST=1 adds asynchronous active-low zeroing of
// every entry; ZERO_RST=0 leaves the storage unreset.
module conv_feeder_rf #(
  parameter int DATA_W   = 14,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter bit ZERO_RST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic signed [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]            i_raddr,
  output logic signed [DATA_W-1:0] o_rdata
);

  logic signed [DATA_W-1:0] r_mem [DEPTH];

  generate
    if (ZERO_RST) begin : g_zero
      // Write port with asynchronous clear of the whole array
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
          r_mem[i_waddr] <= i_wdata;
        end
      end
    end else begin : g_plain
      logic w_unused_rst;
      assign w_unused_rst = rst_n;
      // Write port, storage keeps its contents through reset
      always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
      end
    end
  endgenerate

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/conv_feeder.sv
// conv_feeder: loads filter w[0..M-1] and input x[0..N-1] over a valid/ready
// stream, then sequences operand pairs into a 2-stage MAC to form the valid
// 1-D convolution y[m] = sum_k x[m+k]*w[k], flagging each final y[m].
// Optional feature: define CONV_FEEDER_WKEEP_EN to add keep_w, which lets a
// job reuse the stored filter and load only the N input words.
module conv_feeder
  import conv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = 8,
  parameter int M     = 3,
  localparam int YW   = clog2_min1(N - M + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
`ifdef CONV_FEEDER_WKEEP_EN
  input  logic                    keep_w,
`endif
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic signed [WIDTH-1:0] mac_a,
  output logic signed [WIDTH-1:0] mac_b,
  output logic                    mac_valid,
  output logic                    mac_clr,
  output logic                    y_valid,
  output logic [YW-1:0]           y_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int LDW = clog2_min1(M + N);
  localparam int KW  = clog2_min1(M);
  localparam int XW  = clog2_min1(N);
  localparam int DW  = clog2_min1(MAC_LAT - 1);

  localparam logic [LDW-1:0] LD_LAST_FULL = LDW'(M + N - 1);
  localparam logic [LDW-1:0] LD_LAST_KEEP = LDW'(N - 1);
  localparam logic [LDW-1:0] LD_W_WORDS   = LDW'(M);
  localparam logic [KW-1:0]  K_LAST       = KW'(M - 1);
  localparam logic [YW-1:0]  M_LAST       = YW'(N - M);
  localparam logic [DW-1:0]  D_LAST       = DW'(MAC_LAT - 2);

  state_t           r_state;
  logic [LDW-1:0]   r_ld_cnt;
  logic [KW-1:0]    r_k;
  logic [YW-1:0]    r_m;
  logic [DW-1:0]    r_dcnt;

  logic                    w_keep;
  logic                    w_in_w;
  logic                    w_w_we;
  logic                    w_x_we;
  logic [KW-1:0]           w_w_waddr;
  logic [XW-1:0]           w_x_waddr;
  logic [LDW-1:0]          w_ld_last;
  logic [XW-1:0]           w_x_raddr;
  logic signed [WIDTH-1:0] w_w_rd;
  logic signed [WIDTH-1:0] w_x_rd;

`ifdef CONV_FEEDER_WKEEP_EN
  logic r_keep;
  assign w_keep = r_keep;
`else
  assign w_keep = 1'b0;
`endif

  // Load routing: first M words fill w (unless the filter is kept), the rest fill x
  assign w_in_w    = !w_keep && (r_ld_cnt < LD_W_WORDS);
  assign w_w_we    = (r_state == LOAD) && s_valid && w_in_w;
  assign w_x_we    = (r_state == LOAD) && s_valid && !w_in_w;
  assign w_w_waddr = KW'(r_ld_cnt);
  assign w_x_waddr = w_keep ? XW'(r_ld_cnt) : XW'(r_ld_cnt - LD_W_WORDS);
  assign w_ld_last = w_keep ? LD_LAST_KEEP : LD_LAST_FULL;
  assign w_x_raddr = XW'(r_m) + XW'(r_k);

  conv_feeder_rf #(
    .DATA_W  (WIDTH),
    .DEPTH   (M),
    .AW      (KW),
    .ZERO_RST(1'b1)
  ) u_w_rf (
    .clk    (clk),
    .rst_n  (reset),
    .i_we   (w_w_we),
    .i_waddr(w_w_waddr),
    .i_wdata(s_data),
    .i_raddr(r_k),
    .o_rdata(w_w_rd)
  );

  conv_feeder_rf #(
    .DATA_W  (WIDTH),
    .DEPTH   (N),
    .AW      (XW),
    .ZERO_RST(1'b0)
  ) u_x_rf (
    .clk    (clk),
    .rst_n  (reset),
    .i_we   (w_x_we),
    .i_waddr(w_x_waddr),
    .i_wdata(s_data),
    .i_raddr(w_x_raddr),
    .o_rdata(w_x_rd)
  );

  // Job sequencer: state plus load, tap, window and drain counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ld_cnt <= '0;
      r_k      <= '0;
      r_m      <= '0;
      r_dcnt   <= '0;
`ifdef CONV_FEEDER_WKEEP_EN
      r_keep   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LOAD;
`ifdef CONV_FEEDER_WKEEP_EN
            r_keep  <= keep_w;
`endif
          end
        end
        LOAD: begin
          if (s_valid) begin
            if (r_ld_cnt == w_ld_last) begin
              r_ld_cnt <= '0;
              r_state  <= PRIME;
            end else begin
              r_ld_cnt <= r_ld_cnt + 1'b1;
            end
          end
        end
        PRIME: begin
          r_k     <= '0;
          r_m     <= '0;
          r_state <= ISSUE;
        end
        ISSUE: begin
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_state <= DRAIN1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DRAIN1: begin
          if (r_dcnt == D_LAST) begin
            r_dcnt  <= '0;
            r_state <= DRAIN2;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        DRAIN2: begin
          if (r_m == M_LAST) begin
            r_m     <= '0;
            r_state <= DONE;
          end else begin
            r_m     <= r_m + 1'b1;
            r_state <= ISSUE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Moore output decode from the state and counter flops
  always_comb begin
    s_ready   = (r_state == LOAD);
    mac_valid = (r_state == ISSUE);
    mac_a     = (r_state == ISSUE) ? w_x_rd : '0;
    mac_b     = (r_state == ISSUE) ? w_w_rd : '0;
    mac_clr   = (r_state == PRIME) || (r_state == DRAIN2);
    y_valid   = (r_state == DRAIN2);
    y_idx     = (r_state == DRAIN2) ? r_m : '0;
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
  end

endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: bench for conv_feeder with an attached 2-stage MAC model.
// Expected operand pairs and y values are queued when a job is launched and
// consumed by a monitor as the feeder issues them.
module tb_conv_feeder;

  localparam int WIDTH = 14;
  localparam int N     = 8;
  localparam int M     = 3;
  localparam int NW    = N - M + 1;
  localparam int YW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int JOB_LAT = 1 + NW * (M + 2) + 1;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic signed [WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] mac_a;
  logic signed [WIDTH-1:0] mac_b;
  logic                    mac_valid;
  logic                    mac_clr;
  logic                    y_valid;
  logic [YW-1:0]           y_idx;
  logic                    busy;
  logic                    done;
`ifdef CONV_FEEDER_WKEEP_EN
  logic                    keep_w;
`endif

  conv_feeder #(.WIDTH(WIDTH), .N(N), .M(M)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef CONV_FEEDER_WKEEP_EN
    .keep_w   (keep_w),
`endif
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_valid(mac_valid),
    .mac_clr  (mac_clr),
    .y_valid  (y_valid),
    .y_idx    (y_idx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // MAC model: operands captured at edge 1, accumulated at edge 2, sync clear wins
  logic signed [31:0] mac_p = '0;
  logic               mac_pv = 1'b0;
  logic signed [31:0] f = '0;
  always @(posedge clk) begin
    mac_p  <= mac_a * mac_b;
    mac_pv <= mac_valid;
    if (mac_clr)     f <= '0;
    else if (mac_pv) f <= f + mac_p;
  end

  typedef struct {
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
  } op_t;

  op_t opq[$];
  int  yq[$];
  int  iq[$];
  int  y_seen = 0;

  int jw[M];
  int jx[N];
  int wmod[M];

  // Monitor: scoreboard compare of operands and finished windows
  always @(negedge clk) begin
    op_t e;
    int  ey;
    int  ei;
    n_chk++;
    if (mac_valid) begin
      if (opq.size() == 0) begin
        $display("FAIL op_unexpected got a=%0d b=%0d, required no operand", mac_a, mac_b);
      end else begin
        e = opq.pop_front();
        if (mac_a !== e.a || mac_b !== e.b)
          $display("FAIL op_pair got a=%0d b=%0d, required a=%0d b=%0d", mac_a, mac_b, e.a, e.b);
        else n_pass++;
      end
    end else begin
      if (mac_a !== '0 || mac_b !== '0)
        $display("FAIL op_idle got a=%0d b=%0d, required 0 0", mac_a, mac_b);
      else n_pass++;
    end
    n_chk++;
    if (mac_valid && mac_clr) $display("FAIL valid_clr_overlap got both 1, required not both");
    else n_pass++;
    if (y_valid) begin
      n_chk++;
      if (yq.size() == 0) begin
        $display("FAIL y_stale got y_valid idx=%0d f=%0d, required none", y_idx, f);
      end else begin
        ey = yq.pop_front();
        ei = iq.pop_front();
        if (f !== ey || y_idx !== YW'(ei))
          $display("FAIL y_value got f=%0d idx=%0d, required f=%0d idx=%0d", f, y_idx, ey, ei);
        else n_pass++;
      end
      y_seen++;
    end
  end

  task automatic push_expect();
    op_t e;
    int  y;
    for (int m = 0; m < NW; m++) begin
      y = 0;
      for (int k = 0; k < M; k++) begin
        y += jx[m + k] * wmod[k];
        e.a = WIDTH'(jx[m + k]);
        e.b = WIDTH'(wmod[k]);
        opq.push_back(e);
      end
      yq.push_back(y);
      iq.push_back(m);
    end
  endtask

  task automatic feed_word(input int v, input int maxgap);
    int gap;
    int guard;
    gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
    repeat (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = WIDTH'(v);
    guard   = 0;
    while (s_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_chk++;
      $display("FAIL load_stall got s_ready=%b, required 1", s_ready);
    end
    @(negedge clk);
  endtask

  task automatic launch(input bit keep, input int maxgap);
    @(negedge clk);
    start = 1'b1;
`ifdef CONV_FEEDER_WKEEP_EN
    keep_w = keep;
`endif
    @(negedge clk);
    start = 1'b0;
    if (!keep) for (int k = 0; k < M; k++) feed_word(jw[k], maxgap);
    for (int i = 0; i < N; i++) feed_word(jx[i], maxgap);
    s_valid = 1'b0;
  endtask

  task automatic run_job(input bit keep, input int maxgap, input bit poke, input string nm);
    int lat;
    bit got;
    bit poked;
    if (!keep) wmod = jw;
    push_expect();
    launch(keep, maxgap);
    n_chk++;
    if (s_ready !== 1'b0 || mac_clr !== 1'b1 || busy !== 1'b1)
      $display("FAIL %s_prime got ready=%b clr=%b busy=%b, required 0 1 1", nm, s_ready, mac_clr, busy);
    else n_pass++;
    lat = 1; got = 1'b0; poked = 1'b0;
    while (!got && lat < 200) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        n_chk++;
        if (busy !== 1'b1) $display("FAIL %s_busy got %b at cycle %0d, required 1", nm, busy, lat);
        else n_pass++;
        if (poke && mac_valid && !poked) begin
          start = 1'b1;
          poked = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    n_chk++;
    if (!got || lat != JOB_LAT)
      $display("FAIL %s_latency got done=%b at cycle %0d, required done at cycle %0d", nm, got, lat, JOB_LAT);
    else n_pass++;
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL %s_idle got busy=%b ready=%b done=%b, required 0 0 0", nm, busy, s_ready, done);
    else n_pass++;
    n_chk++;
    if (yq.size() != 0 || opq.size() != 0)
      $display("FAIL %s_drain got %0d y and %0d ops pending, required 0 0", nm, yq.size(), opq.size());
    else n_pass++;
  endtask

  task automatic check_quiet(input string nm);
    n_chk++;
    if (s_ready !== 0 || mac_valid !== 0 || mac_clr !== 0 || mac_a !== 0 || mac_b !== 0 ||
        y_valid !== 0 || y_idx !== 0 || busy !== 0 || done !== 0)
      $display("FAIL %s got rdy=%b v=%b clr=%b a=%0d b=%0d yv=%b idx=%0d busy=%b done=%b, required all 0",
               nm, s_ready, mac_valid, mac_clr, mac_a, mac_b, y_valid, y_idx, busy, done);
    else n_pass++;
  endtask

  task automatic set_basic();
    for (int k = 0; k < M; k++) jw[k] = k + 1;
    for (int i = 0; i < N; i++) jx[i] = i + 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_quiet("reset_state");
    start = 1'b1;
    @(negedge clk);
    check_quiet("reset_beats_start");
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_quiet("idle_after_reset");
  endtask

  task automatic test_basic();
    set_basic();
    run_job(1'b0, 0, 1'b1, "basic");
  endtask

  task automatic test_extremes();
    jw[0] = -8192; jw[1] = 0; jw[2] = 8191;
    for (int i = 0; i < N; i++) jx[i] = -8192;
    run_job(1'b0, 0, 1'b0, "extremes");
  endtask

  task automatic test_gaps();
    set_basic();
    run_job(1'b0, 3, 1'b0, "gaps");
  endtask

  task automatic test_reset_midjob();
    int base;
    int guard;
    set_basic();
    wmod = jw;
    push_expect();
    base = y_seen;
    launch(1'b0, 0);
    guard = 0;
    while (!(y_seen >= base + 2 && mac_valid === 1'b1) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (guard >= 200) $display("FAIL midjob_reach got %0d windows, required 2", y_seen - base);
    else n_pass++;
    reset = 1'b0;
    #1;
    check_quiet("midjob_reset_now");
    opq.delete();
    yq.delete();
    iq.delete();
    for (int k = 0; k < M; k++) wmod[k] = 0;
    @(negedge clk);
    check_quiet("midjob_reset_next");
    reset = 1'b1;
    @(negedge clk);
    check_quiet("midjob_idle");
    run_job(1'b0, 0, 1'b0, "restart");
  endtask

`ifdef CONV_FEEDER_WKEEP_EN
  task automatic test_keep();
    for (int i = 0; i < N; i++) jx[i] = N - i;
    run_job(1'b1, 0, 1'b0, "keep");
  endtask
`endif

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
`ifdef CONV_FEEDER_WKEEP_EN
    keep_w  = 1'b0;
`endif
    test_reset();
    test_basic();
    test_extremes();
    test_gaps();
    test_reset_midjob();
`ifdef CONV_FEEDER_WKEEP_EN
    test_keep();
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got no finish by 300000ns, required completion");
    $fatal(1, "timeout");
  end

endmodule
